// File: rtl/video_timing_analyzer.sv
//------------------------------------------------------------------------------
// Module   : video_timing_analyzer
// Measures line/frame timing of a sync+valid video stream and tracks lock.
// Optional : define VTA_FRAME_CRC_EN to add a per-frame CRC-16-CCITT of pixels.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_timing_analyzer #(
  parameter logic [11:0] H_VAL = 12'd1080,
  parameter logic [11:0] V_VAL = 12'd1920
) (
  input  logic        px_clk,
  input  logic        rstn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        dval,
  input  logic [23:0] px_data,
  input  logic        clr_err,
  output logic [15:0] meas_h_act,
  output logic [15:0] meas_h_total,
  output logic [15:0] meas_v_act,
  output logic [15:0] meas_v_total,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_crc
);

  localparam logic [1:0]  c_SEARCH  = 2'd0;
  localparam logic [1:0]  c_MEASURE = 2'd1;
  localparam logic [1:0]  c_LOCKED  = 2'd2;
  localparam logic [15:0] c_H_VAL16 = {4'd0, H_VAL};
  localparam logic [15:0] c_V_VAL16 = {4'd0, V_VAL};

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        r_hs, r_vs, r_dv, r_hs_d, r_vs_d, r_dv_d;
  logic [15:0] r_h_tot, r_line_px, r_last_h_act, r_v_tot, r_v_act;
  logic        r_dv_seen, r_frm_err;
  logic [15:0] r_meas_h_act, r_meas_h_total, r_meas_v_act, r_meas_v_total;
  logic [15:0] r_frame_cnt;
  logic        r_frame_done, r_h_err, r_v_err;
  logic [1:0]  r_state, w_next;
  logic        w_locked;

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_dv   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_dv_d <= 1'b0;
    end else begin
      r_hs   <= hsync;
      r_vs   <= vsync;
      r_dv   <= dval;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_dv_d <= r_dv;
    end
  end

  logic        w_hs_rise, w_vs_rise, w_dv_rise, w_line_close, w_line_active;
  logic        w_h_err_set, w_v_err_set, w_frame_close, w_frame_err, w_meas_change;
  logic [15:0] w_v_tot_fin, w_v_act_fin, w_h_act_fin;

  // A vsync rise also closes the line in progress, before the frame is closed.
  assign w_hs_rise     = r_hs & ~r_hs_d;
  assign w_vs_rise     = r_vs & ~r_vs_d;
  assign w_dv_rise     = r_dv & ~r_dv_d;
  assign w_line_close  = w_hs_rise | w_vs_rise;
  assign w_line_active = (r_line_px != 16'd0);
  assign w_frame_close = w_vs_rise & (r_state != c_SEARCH);
  assign w_h_err_set   = (r_state != c_SEARCH) &
                         ((w_line_close & w_line_active & (r_line_px != c_H_VAL16)) |
                          (~w_line_close & w_dv_rise & r_dv_seen));
  assign w_v_tot_fin   = f_sat_inc(r_v_tot);
  assign w_v_act_fin   = w_line_active ? f_sat_inc(r_v_act) : r_v_act;
  assign w_h_act_fin   = w_line_active ? r_line_px : r_last_h_act;
  assign w_v_err_set   = w_frame_close & (w_v_act_fin != c_V_VAL16);
  assign w_frame_err   = r_frm_err | w_h_err_set | w_v_err_set;
  assign w_meas_change = (w_v_tot_fin != r_meas_v_total) | (r_h_tot != r_meas_h_total);

  // A new line starts at 1 cycle (the rise cycle itself) and at 1 pixel if dval is high then.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_h_tot      <= 16'd0;
      r_line_px    <= 16'd0;
      r_last_h_act <= 16'd0;
      r_dv_seen    <= 1'b0;
      r_v_tot      <= 16'd0;
      r_v_act      <= 16'd0;
    end else begin
      if (w_line_close) begin
        r_h_tot   <= 16'd1;
        r_line_px <= r_dv ? 16'd1 : 16'd0;
        r_dv_seen <= w_dv_rise;
        if (w_line_active)
          r_last_h_act <= r_line_px;
      end else begin
        r_h_tot <= f_sat_inc(r_h_tot);
        if (r_dv)
          r_line_px <= f_sat_inc(r_line_px);
        if (w_dv_rise)
          r_dv_seen <= 1'b1;
      end
      if (w_vs_rise) begin
        r_v_tot <= 16'd0;
        r_v_act <= 16'd0;
      end else if (w_line_close) begin
        r_v_tot <= w_v_tot_fin;
        r_v_act <= w_v_act_fin;
      end
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_meas_h_act   <= 16'd0;
      r_meas_h_total <= 16'd0;
      r_meas_v_act   <= 16'd0;
      r_meas_v_total <= 16'd0;
      r_frame_cnt    <= 16'd0;
      r_frame_done   <= 1'b0;
      r_frm_err      <= 1'b0;
      r_h_err        <= 1'b0;
      r_v_err        <= 1'b0;
    end else begin
      r_frame_done <= w_frame_close;
      if (w_frame_close) begin
        r_meas_h_act   <= w_h_act_fin;
        r_meas_h_total <= r_h_tot;
        r_meas_v_act   <= w_v_act_fin;
        r_meas_v_total <= w_v_tot_fin;
        r_frame_cnt    <= r_frame_cnt + 16'd1;
      end
      if (w_vs_rise)
        r_frm_err <= 1'b0;
      else if (w_h_err_set)
        r_frm_err <= 1'b1;
      r_h_err <= w_h_err_set | (r_h_err & ~clr_err);
      r_v_err <= w_v_err_set | (r_v_err & ~clr_err);
    end
  end

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn)
      r_state <= c_SEARCH;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_SEARCH:  if (w_vs_rise) w_next = c_MEASURE;
      c_MEASURE: if (w_frame_close && !w_frame_err) w_next = c_LOCKED;
      c_LOCKED:  if (w_frame_close && (w_frame_err || w_meas_change)) w_next = c_MEASURE;
      default:   w_next = c_SEARCH;
    endcase
  end

  always_comb begin
    w_locked = (r_state == c_LOCKED);
  end

`ifdef VTA_FRAME_CRC_EN
  function automatic logic [15:0] f_crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  logic [23:0] r_px;
  logic [15:0] r_crc, r_frame_crc;

  // A pixel on the vsync-rise cycle belongs to the new frame.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_px        <= 24'd0;
      r_crc       <= 16'hFFFF;
      r_frame_crc <= 16'd0;
    end else begin
      r_px <= px_data;
      if (w_vs_rise) begin
        r_crc <= r_dv ? f_crc24(16'hFFFF, r_px) : 16'hFFFF;
        if (w_frame_close)
          r_frame_crc <= r_crc;
      end else if (r_dv) begin
        r_crc <= f_crc24(r_crc, r_px);
      end
    end
  end

  assign frame_crc = r_frame_crc;
`else
  logic w_unused_px;
  assign w_unused_px = ^px_data;
  assign frame_crc   = 16'h0000;
`endif

  assign meas_h_act   = r_meas_h_act;
  assign meas_h_total = r_meas_h_total;
  assign meas_v_act   = r_meas_v_act;
  assign meas_v_total = r_meas_v_total;
  assign frame_cnt    = r_frame_cnt;
  assign frame_done   = r_frame_done;
  assign locked       = w_locked;
  assign h_err        = r_h_err;
  assign v_err        = r_v_err;

endmodule

`default_nettype wire
